// File: rtl/arbiter_2to1.sv
// Round-robin 2:1 arbiter between two processing slaves and a shared result FIFO.
// The granted beat is registered onto the slvx stream one cycle after acceptance.
module arbiter_2to1 #(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fifo_full_i,
  input  logic          mstr0_cmplt_i,
  input  logic [1:0]    slv0_mode_i,
  input  logic [1:0]    slv1_mode_i,
  input  logic          slv0_data_valid_i,
  input  logic          slv1_data_valid_i,
  input  logic [7:0]    slv0_proc_valid_i,
  input  logic [7:0]    slv1_proc_valid_i,
  input  logic [DW-1:0] slv0_data_i,
  input  logic [DW-1:0] slv1_data_i,
  output logic [1:0]    slvx_mode_o,
  output logic          slvx_data_valid_o,
  output logic [7:0]    slvx_proc_val_o,
  output logic [DW-1:0] slvx_data_o,
  output logic          slv0_ready_o,
  output logic          slv1_ready_o
);

  typedef enum logic {StPri0, StPri1} pri_e;

  pri_e          pri_q, pri_d;
  logic [DW-1:0] data_q, data_d;
  logic [1:0]    mode_q, mode_d;
  logic [7:0]    pv_q, pv_d;
  logic          dv_q, dv_d;
  logic          req0, req1;
  logic          grant0, grant1;

  // Case equality keeps X/Z requests from being granted in simulation.
  assign req0 = (slv0_data_valid_i === 1'b1);
  assign req1 = (slv1_data_valid_i === 1'b1);

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_n && !fifo_full_i) begin
      if (req0 && req1) begin
        grant0 = (pri_q == StPri0);
        grant1 = (pri_q == StPri1);
      end else begin
        grant0 = req0;
        grant1 = req1;
      end
    end
  end

  assign slv0_ready_o = grant0;
  assign slv1_ready_o = grant1;

  always_comb begin
    pri_d  = pri_q;
    data_d = data_q;
    mode_d = mode_q;
    pv_d   = pv_q;
    dv_d   = 1'b0;
    if (grant0) begin
      data_d = slv0_data_i;
      mode_d = slv0_mode_i;
      pv_d   = slv0_proc_valid_i;
      dv_d   = 1'b1;
      pri_d  = StPri1;
    end else if (grant1) begin
      data_d = slv1_data_i;
      mode_d = slv1_mode_i;
      pv_d   = slv1_proc_valid_i;
      dv_d   = 1'b1;
      pri_d  = StPri0;
    end
    // Master-0 completion re-arms slave 0 regardless of this cycle's grant.
    if (mstr0_cmplt_i) begin
      pri_d = StPri0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pri_q  <= StPri0;
      data_q <= '0;
      mode_q <= '0;
      pv_q   <= '0;
      dv_q   <= 1'b0;
    end else begin
      pri_q  <= pri_d;
      data_q <= data_d;
      mode_q <= mode_d;
      pv_q   <= pv_d;
      dv_q   <= dv_d;
    end
  end

  assign slvx_data_o       = data_q;
  assign slvx_mode_o       = mode_q;
  assign slvx_proc_val_o   = pv_q;
  assign slvx_data_valid_o = dv_q;

endmodule

// File: tb/tb_arbiter_2to1.sv
// Directed-vector bench for arbiter_2to1 with hand-computed expectations.
module tb_arbiter_2to1;

  localparam int unsigned DW = 32;

  logic          clk;
  logic          rst_n;
  logic          fifo_full;
  logic          mstr0_cmplt;
  logic [1:0]    slv0_mode, slv1_mode;
  logic          slv0_dv, slv1_dv;
  logic [7:0]    slv0_pv, slv1_pv;
  logic [DW-1:0] slv0_data, slv1_data;
  logic [1:0]    slvx_mode;
  logic          slvx_dv;
  logic [7:0]    slvx_pv;
  logic [DW-1:0] slvx_data;
  logic          slv0_ready, slv1_ready;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  arbiter_2to1 #(.DW(DW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .fifo_full_i       (fifo_full),
    .mstr0_cmplt_i     (mstr0_cmplt),
    .slv0_mode_i       (slv0_mode),
    .slv1_mode_i       (slv1_mode),
    .slv0_data_valid_i (slv0_dv),
    .slv1_data_valid_i (slv1_dv),
    .slv0_proc_valid_i (slv0_pv),
    .slv1_proc_valid_i (slv1_pv),
    .slv0_data_i       (slv0_data),
    .slv1_data_i       (slv1_data),
    .slvx_mode_o       (slvx_mode),
    .slvx_data_valid_o (slvx_dv),
    .slvx_proc_val_o   (slvx_pv),
    .slvx_data_o       (slvx_data),
    .slv0_ready_o      (slv0_ready),
    .slv1_ready_o      (slv1_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Check readies on the current inputs, clock once, then check the registered beat.
  task automatic step(input string tag, input logic r0, input logic r1,
                      input logic dv, input logic [DW-1:0] data,
                      input logic [1:0] mode, input logic [7:0] pv);
    #1;
    check_val({tag, ".ready0"}, 64'(slv0_ready), 64'(r0));
    check_val({tag, ".ready1"}, 64'(slv1_ready), 64'(r1));
    @(posedge clk);
    #1;
    check_val({tag, ".dv"},   64'(slvx_dv),   64'(dv));
    check_val({tag, ".data"}, 64'(slvx_data), 64'(data));
    check_val({tag, ".mode"}, 64'(slvx_mode), 64'(mode));
    check_val({tag, ".pv"},   64'(slvx_pv),   64'(pv));
  endtask

  initial begin
    rst_n       = 1'b0;
    fifo_full   = 1'b0;
    mstr0_cmplt = 1'b0;
    slv0_dv     = 1'b1;
    slv1_dv     = 1'b1;
    slv0_data   = 32'hA0;
    slv1_data   = 32'hB0;
    slv0_mode   = 2'd0;
    slv1_mode   = 2'd1;
    slv0_pv     = 8'hFF;
    slv1_pv     = 8'hFF;

    // Reset held with both requests active.
    #3;
    check_val("rst.ready0", 64'(slv0_ready), 64'd0);
    check_val("rst.ready1", 64'(slv1_ready), 64'd0);
    check_val("rst.dv",     64'(slvx_dv),    64'd0);
    check_val("rst.data",   64'(slvx_data),  64'd0);
    check_val("rst.mode",   64'(slvx_mode),  64'd0);
    check_val("rst.pv",     64'(slvx_pv),    64'd0);
    @(posedge clk);
    #1;
    check_val("rst.hold.dv", 64'(slvx_dv), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Both valid: strict alternation starting with slv0.
    step("rr0", 1'b1, 1'b0, 1'b1, 32'hA0, 2'd0, 8'hFF);
    step("rr1", 1'b0, 1'b1, 1'b1, 32'hB0, 2'd1, 8'hFF);
    step("rr2", 1'b1, 1'b0, 1'b1, 32'hA0, 2'd0, 8'hFF);

    // Idle: outputs hold, valid drops.
    slv0_dv = 1'b0;
    slv1_dv = 1'b0;
    for (int i = 0; i < 3; i++) step("idle", 1'b0, 1'b0, 1'b0, 32'hA0, 2'd0, 8'hFF);

    // Only slv1 requests (priority currently favours slv1 but irrelevant).
    slv1_dv   = 1'b1;
    slv1_data = 32'hC3;
    slv1_mode = 2'd2;
    slv1_pv   = 8'h0F;
    step("solo1a", 1'b0, 1'b1, 1'b1, 32'hC3, 2'd2, 8'h0F);
    step("solo1b", 1'b0, 1'b1, 1'b1, 32'hC3, 2'd2, 8'h0F);

    // FIFO full blocks both; priority is PRI0 after the slv1 grants.
    slv0_dv   = 1'b1;
    slv1_data = 32'hB0;
    slv1_mode = 2'd1;
    slv1_pv   = 8'hFF;
    fifo_full = 1'b1;
    step("full0", 1'b0, 1'b0, 1'b0, 32'hC3, 2'd2, 8'h0F);
    step("full1", 1'b0, 1'b0, 1'b0, 32'hC3, 2'd2, 8'h0F);
    fifo_full = 1'b0;
    step("resume0", 1'b1, 1'b0, 1'b1, 32'hA0, 2'd0, 8'hFF);
    step("resume1", 1'b0, 1'b1, 1'b1, 32'hB0, 2'd1, 8'hFF);
    step("resume2", 1'b1, 1'b0, 1'b1, 32'hA0, 2'd0, 8'hFF);

    // Now PRI1: pulse mstr0_cmplt with no requests, then slv0 must win.
    slv0_dv     = 1'b0;
    slv1_dv     = 1'b0;
    mstr0_cmplt = 1'b1;
    step("cmplt", 1'b0, 1'b0, 1'b0, 32'hA0, 2'd0, 8'hFF);
    mstr0_cmplt = 1'b0;
    slv0_dv     = 1'b1;
    slv1_dv     = 1'b1;
    step("cmplt.first", 1'b1, 1'b0, 1'b1, 32'hA0, 2'd0, 8'hFF);
    step("cmplt.next",  1'b0, 1'b1, 1'b1, 32'hB0, 2'd1, 8'hFF);

    // PRI0: cmplt with a slv0 grant still transfers and keeps slv0 favoured.
    mstr0_cmplt = 1'b1;
    step("cmplt.xfer", 1'b1, 1'b0, 1'b1, 32'hA0, 2'd0, 8'hFF);
    mstr0_cmplt = 1'b0;
    step("cmplt.again", 1'b1, 1'b0, 1'b1, 32'hA0, 2'd0, 8'hFF);

    // Unknown request must not be granted.
    slv0_dv = 1'bx;
    step("xreq", 1'b0, 1'b1, 1'b1, 32'hB0, 2'd1, 8'hFF);
    slv0_dv = 1'b1;

    // Asynchronous reset mid-stream clears outputs immediately.
    #2;
    rst_n = 1'b0;
    #1;
    check_val("midrst.dv",     64'(slvx_dv),    64'd0);
    check_val("midrst.data",   64'(slvx_data),  64'd0);
    check_val("midrst.ready0", 64'(slv0_ready), 64'd0);
    check_val("midrst.ready1", 64'(slv1_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step("postrst", 1'b1, 1'b0, 1'b1, 32'hA0, 2'd0, 8'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
